// File: rtl/serial_to_parallel_aligner.sv
// Serial-to-parallel converter with polarity inversion, K28.5 comma alignment and a HUNT/VERIFY/LOCKED symbol-lock FSM.
// Optional: define S2P_REALIGN_CNT_EN to add the saturating Realign_Count output.
module serial_to_parallel_aligner #(
    parameter int DATA_WIDTH    = 10,
    parameter int LOCK_COMMAS   = 3,
    parameter int UNLOCK_MISSES = 4
) (
    input  logic                       Recovered_Bit_Clk,
    input  logic                       Rst,
    input  logic                       Ser_in,
    input  logic                       RxPolarity,
    input  logic                       Comma_Det_En,
    output logic [DATA_WIDTH-1:0]      Data_to_Decoder,
    output logic                       Data_Valid,
    output logic [DATA_WIDTH/10-1:0]   K285,
    output logic                       Symbol_Lock
`ifdef S2P_REALIGN_CNT_EN
    ,
    output logic [7:0]                 Realign_Count
`endif
);

    localparam int SYMBOLS = DATA_WIDTH / 10;
    localparam int BCW     = $clog2(DATA_WIDTH);
    localparam logic [9:0] COMMA_NEG = 10'h17C;
    localparam logic [9:0] COMMA_POS = 10'h283;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [DATA_WIDTH-1:0]  sr, nxt;
    logic [BCW-1:0]         bit_cnt, bit_cnt_nxt, pos;
    logic [7:0]             match_cnt, match_nxt;
    logic [7:0]             miss_cnt, miss_nxt;
    logic                   b, comma_hit, aligned, realign, emit;
    logic [SYMBOLS-1:0]     k_nxt;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == COMMA_NEG) || (sym == COMMA_POS);
    endfunction

    always_comb begin
        b         = Ser_in ^ RxPolarity;
        nxt       = {b, sr[DATA_WIDTH-1:1]};
        comma_hit = is_comma(nxt[DATA_WIDTH-1 -: 10]);
        // A comma completing symbol 0 or symbol 1 both sit on the current boundary
        aligned   = (bit_cnt == BCW'(9)) || (bit_cnt == BCW'(DATA_WIDTH-1));

        state_nxt = state;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        realign   = 1'b0;

        if (Comma_Det_En && comma_hit) begin
            case (state)
                HUNT: begin
                    realign   = 1'b1;
                    match_nxt = 8'd1;
                    if (LOCK_COMMAS == 1) begin
                        state_nxt = LOCKED;
                        miss_nxt  = 8'd0;
                    end else begin
                        state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (aligned) begin
                        match_nxt = match_cnt + 8'd1;
                        if (match_nxt == 8'(LOCK_COMMAS)) begin
                            state_nxt = LOCKED;
                            miss_nxt  = 8'd0;
                        end
                    end else begin
                        realign   = 1'b1;
                        match_nxt = 8'd1;
                    end
                end
                LOCKED: begin
                    if (aligned) begin
                        miss_nxt = 8'd0;
                    end else begin
                        miss_nxt = miss_cnt + 8'd1;
                        if (miss_nxt == 8'(UNLOCK_MISSES)) begin
                            state_nxt = HUNT;
                            match_nxt = 8'd0;
                            miss_nxt  = 8'd0;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end

        // Realign places the comma's last bit at position 9, making it symbol 0
        pos         = realign ? BCW'(9) : bit_cnt;
        emit        = (pos == BCW'(DATA_WIDTH-1));
        bit_cnt_nxt = emit ? '0 : pos + BCW'(1);

        k_nxt = '0;
        for (int s = 0; s < SYMBOLS; s++) begin
            k_nxt[s] = is_comma(nxt[10*s +: 10]);
        end
    end

    always_ff @(posedge Recovered_Bit_Clk) begin
        if (Rst) begin
            sr              <= '0;
            bit_cnt         <= '0;
            state           <= HUNT;
            match_cnt       <= '0;
            miss_cnt        <= '0;
            Symbol_Lock     <= 1'b0;
            Data_Valid      <= 1'b0;
            Data_to_Decoder <= '0;
            K285            <= '0;
        end else begin
            sr          <= nxt;
            bit_cnt     <= bit_cnt_nxt;
            state       <= state_nxt;
            match_cnt   <= match_nxt;
            miss_cnt    <= miss_nxt;
            Symbol_Lock <= (state_nxt == LOCKED);
            Data_Valid  <= emit;
            if (emit) begin
                Data_to_Decoder <= nxt;
                K285            <= k_nxt;
            end
        end
    end

`ifdef S2P_REALIGN_CNT_EN
    logic unlock;
    assign unlock = (state == LOCKED) && (state_nxt == HUNT);

    always_ff @(posedge Recovered_Bit_Clk) begin
        if (Rst) begin
            Realign_Count <= 8'd0;
        end else if ((realign || unlock) && (Realign_Count != 8'hFF)) begin
            Realign_Count <= Realign_Count + 8'd1;
        end
    end
`endif

endmodule
